// File: rtl/ahb_master_req_ctrl_pkg.sv
// rtl/ahb_master_req_ctrl_pkg.sv - shared AHB types, master state enum and burst length helper
package ahb_master_req_ctrl_pkg;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_type;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_LAST  = 2'd3
    } mst_state_t;

    // Number of beats in a burst; len (beats-1) only matters for undefined-length INCR
    function automatic logic [4:0] burst_beats(input hburst_type burst, input logic [3:0] len);
        logic [4:0] beats;
        case (burst)
            HB_SINGLE:            beats = 5'd1;
            HB_INCR:              beats = {1'b0, len} + 5'd1;
            HB_WRAP4,  HB_INCR4:  beats = 5'd4;
            HB_WRAP8,  HB_INCR8:  beats = 5'd8;
            HB_WRAP16, HB_INCR16: beats = 5'd16;
            default:              beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_if.sv
// rtl/ahb_master_req_ctrl_if.sv - command and AHB request bundle; prior signals under AHB_MASTER_DYNAMIC_PRIOR_EN
interface ahb_master_req_ctrl_if #(
    parameter int ADDR_W = 32
`ifdef AHB_MASTER_DYNAMIC_PRIOR_EN
    ,
    parameter int PRIOR_BIT = 1
`endif
);
    import ahb_master_req_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    hburst_type        cmd_burst;
    logic [3:0]        cmd_len;
    logic              cmd_write;
    logic              hreq;
    hburst_type        hburst;
    logic              hgrant;
    logic              hwait;
    logic [ADDR_W-1:0] haddr;
    htrans_type        htrans;
    logic              hwrite;
    logic              done;
`ifdef AHB_MASTER_DYNAMIC_PRIOR_EN
    logic [PRIOR_BIT-1:0] cmd_prior;
    logic [PRIOR_BIT-1:0] hprior;
`endif

    modport master (
`ifdef AHB_MASTER_DYNAMIC_PRIOR_EN
        input  cmd_prior,
        output hprior,
`endif
        input  cmd_valid, cmd_addr, cmd_burst, cmd_len, cmd_write, hgrant, hwait,
        output cmd_ready, hreq, hburst, haddr, htrans, hwrite, done
    );

    modport slave (
`ifdef AHB_MASTER_DYNAMIC_PRIOR_EN
        output cmd_prior,
        input  hprior,
`endif
        output cmd_valid, cmd_addr, cmd_burst, cmd_len, cmd_write, hgrant, hwait,
        input  cmd_ready, hreq, hburst, haddr, htrans, hwrite, done
    );

endinterface

// File: rtl/ahb_master_req_ctrl_addr_gen.sv
// rtl/ahb_master_req_ctrl_addr_gen.sv - combinational next-beat address for INCR and WRAP bursts
module ahb_burst_addr_gen
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  hburst_type        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_BYTES);
    localparam logic [ADDR_W-1:0] MASK_4  = ADDR_W'(4 * DATA_BYTES - 1);
    localparam logic [ADDR_W-1:0] MASK_8  = ADDR_W'(8 * DATA_BYTES - 1);
    localparam logic [ADDR_W-1:0] MASK_16 = ADDR_W'(16 * DATA_BYTES - 1);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap;

    // Wrapping bursts step only the bits below the wrap boundary; others step linearly
    always_comb begin
        incr_addr = addr_i + STEP;
        wrap      = 1'b1;
        case (burst_i)
            HB_WRAP4:  wrap_mask = MASK_4;
            HB_WRAP8:  wrap_mask = MASK_8;
            HB_WRAP16: wrap_mask = MASK_16;
            default: begin
                wrap_mask = '0;
                wrap      = 1'b0;
            end
        endcase
        next_addr_o = wrap ? ((addr_i & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
    end

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// rtl/ahb_master_req_ctrl.sv - AHB master request/burst controller; optional AHB_MASTER_DYNAMIC_PRIOR_EN
module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
`ifdef AHB_MASTER_DYNAMIC_PRIOR_EN
    ,
    parameter int PRIOR_LEVEL = 2,
    parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL)
`endif
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    ahb_master_req_ctrl_if.master bus
);

    mst_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_addr;
    hburst_type        burst_q, burst_d;
    logic [3:0]        last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic [4:0]        cmd_beats;

    assign cmd_beats = burst_beats(bus.cmd_burst, bus.cmd_len);

    ahb_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // State and captured-command registers
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            burst_q <= HB_SINGLE;
            last_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            done_q  <= done_d;
        end
    end

    // Next state, beat counting and bus outputs; the counter stops at the last beat index
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        burst_d        = burst_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        write_d        = write_q;
        done_d         = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.hreq       = 1'b0;
        bus.hburst     = HB_SINGLE;
        bus.htrans     = HT_IDLE;
        bus.haddr      = '0;
        bus.hwrite     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    burst_d = bus.cmd_burst;
                    last_d  = 4'(cmd_beats - 5'd1);
                    cnt_d   = '0;
                    write_d = bus.cmd_write;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.hreq   = 1'b1;
                bus.hburst = burst_q;
                bus.htrans = HT_NONSEQ;
                bus.haddr  = addr_q;
                bus.hwrite = write_q;
                if (bus.hgrant) begin
                    if (last_q == 4'd0) begin
                        state_d = ST_LAST;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = next_addr;
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                bus.hreq   = 1'b1;
                bus.hburst = burst_q;
                bus.htrans = HT_SEQ;
                bus.haddr  = addr_q;
                bus.hwrite = write_q;
                if (bus.hgrant) begin
                    if (cnt_q == last_q) begin
                        state_d = ST_LAST;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = next_addr;
                    end
                end
            end
            ST_LAST: begin
                bus.hburst = burst_q;
                bus.haddr  = addr_q;
                bus.hwrite = write_q;
                if (!bus.hwait) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.done = done_q;

`ifdef AHB_MASTER_DYNAMIC_PRIOR_EN
    logic [PRIOR_BIT-1:0] prior_q;

    // Priority latched with the command; shown only while a transaction is in flight
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            prior_q <= '0;
        end else if (state_q == ST_IDLE && bus.cmd_valid) begin
            prior_q <= bus.cmd_prior;
        end
    end

    assign bus.hprior = (state_q == ST_IDLE) ? '0 : prior_q;
`endif

endmodule

// File: doc/ahb_master_req_ctrl.md
Name: ahb_master_req_ctrl

Overview:
- Master-side counterpart of the per-slave arbiter. Turns a local command (address, burst type, direction) into hreq/hburst toward the arbiter, waits for hgrant, then issues the burst beat by beat.
- Drives haddr/htrans/hwrite and counts beats so hreq drops after the last beat. This lets the arbiter's burst monitor see a clean transaction end.
- One instance sits per master, between the master core and the interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_BYTES, 4, bytes per beat; sets the address increment. Power of two.
- PRIOR_LEVEL, 2, priority levels accepted by the arbiter.
- PRIOR_BIT, $clog2(PRIOR_LEVEL), hprior width.

Ports:
- hclk  in  1  clock.
- hreset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  ADDR_W  start address, aligned to DATA_BYTES.
- cmd_burst  in  hburst_type  burst type.
- cmd_len  in  4  beats-1; used only for INCR.
- cmd_write  in  1  1 = write.
- cmd_prior  in  PRIOR_BIT  priority; present only with the optional feature.
- hreq  out  1  request to arbiter.
- hburst  out  hburst_type  burst type of the current request.
- hprior  out  PRIOR_BIT  priority; present only with the optional feature.
- hgrant  in  1  arbiter grant, already qualified by ~hwait. A beat is accepted when hgrant=1.
- hwait  in  1  slave wait; extends the current data phase.
- haddr  out  ADDR_W  beat address.
- htrans  out  htrans_type  IDLE/NONSEQ/SEQ.
- hwrite  out  1  direction.
- done  out  1  one-cycle pulse when the final data phase completes.

Behaviour:
- Reset values: all outputs 0, htrans=IDLE, hburst=SINGLE. Asserting reset mid-burst aborts immediately to IDLE; no done pulse.
- Command capture, IDLE state:
  - cmd_ready=1 only in IDLE.
  - On handshake, register addr/burst/len/write(/prior).
  - Set beat_total: SINGLE=1, INCR=cmd_len+1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
  - Clear beat_cnt. Go to REQ next cycle.
- REQ state:
  - hreq=1, hburst=registered type, htrans=NONSEQ, haddr=start.
  - Hold until hgrant=1. That cycle counts beat 0.
  - If beat_total=1, go to LAST; else go to BURST.
- BURST state:
  - hreq=1, htrans=SEQ.
  - Each cycle with hgrant=1: beat_cnt+1 and advance haddr.
  - When the accepted beat is beat_total-1, go to LAST.
  - hgrant=0 (wait or grant lost): hold haddr/htrans/beat_cnt unchanged and keep hreq.
- LAST state:
  - hreq=0, htrans=IDLE.
  - Stay while hwait=1. On hwait=0, pulse done and go to IDLE.
- Address rules:
  - INCR*/INCR/SINGLE: haddr += DATA_BYTES.
  - WRAPn: boundary = n*DATA_BYTES. Lower log2(boundary) bits increment modulo boundary; upper bits are held.
- Beat counter: 4-bit, never exceeds beat_total-1. A 16-beat burst ends at count 15 with no overflow.
- Latency:
  - cmd handshake to hreq: 1 cycle.
  - Last grant to hreq low: 1 cycle.
  - done: the cycle after the final hwait=0 in LAST.
- A cmd_valid during a burst is ignored until the return to IDLE. Back-to-back commands leave at least one cycle of hreq=0 between transactions.

Optional Feature:
- Macro: AHB_MASTER_DYNAMIC_PRIOR_EN.
- Defined: cmd_prior and hprior ports exist. hprior is registered at command capture and held constant through REQ/BURST/LAST. It is 0 in IDLE.
- Undefined: both ports are absent and no priority register is built. For use with fixed-priority or round-robin arbiters.

Decomposition:
- AHB_package already holds hburst_type. Add htrans_type (IDLE, BUSY, NONSEQ, SEQ), the master state enum, and a function burst_beats(hburst_type, len) returning beat_total.
- One sub-module is natural: ahb_burst_addr_gen.
  - Combinational next-address from current addr, burst type and DATA_BYTES.
  - Reused by future master ports.

Test Plan:
- SINGLE write at 0x100, hgrant asserted 2 cycles after hreq: htrans NONSEQ once, haddr=0x100. hreq low the cycle after grant; done 1 cycle later.
- INCR4 at 0x200 with continuous grant: haddr 0x200, 0x204, 0x208, 0x20C. htrans NONSEQ, SEQ, SEQ, SEQ. hreq drops after the 4th beat.
- WRAP4 at 0x38: haddr 0x38, 0x3C, 0x30, 0x34. WRAP8 at 0x1C: 0x1C, 0x00, 0x04, ..., 0x18.
- INCR8 with hwait=1 for 3 cycles at beat 5: haddr/htrans frozen at 0x214/SEQ, beat count unchanged. Resumes and completes 8 beats.
- Reset asserted mid-INCR16 at beat 9: hreq, htrans and done return to 0/IDLE/0 immediately. After release, cmd_ready=1 and a new SINGLE completes normally.
- With AHB_MASTER_DYNAMIC_PRIOR_EN, cmd_prior=1: hprior=1 for the whole transaction and 0 in IDLE. A cmd_valid pulse mid-burst is not accepted.
